// File: rtl/hvac_pkg.sv
// Shared types and constants for the HVAC sequencing controller.
// Covers the FSM states, the heat/cool direction, fan speed codes and the timer width.
package hvac_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StRun  = 2'd2,
    StPost = 2'd3
  } state_e;

  typedef enum logic {
    DirHeat = 1'b0,
    DirCool = 1'b1
  } dir_e;

  localparam logic [1:0] SpdOff  = 2'd0;
  localparam logic [1:0] SpdLow  = 2'd1;
  localparam logic [1:0] SpdMid  = 2'd2;
  localparam logic [1:0] SpdHigh = 2'd3;

  localparam int unsigned SpdMidMag  = 3;
  localparam int unsigned SpdHighMag = 6;

  localparam int unsigned TimerW = 16;

  // Fan speed while running, graded by the temperature error magnitude.
  function automatic logic [1:0] run_speed(input int unsigned mag);
    if (mag >= SpdHighMag) return SpdHigh;
    if (mag >= SpdMidMag) return SpdMid;
    return SpdLow;
  endfunction

endpackage

// File: rtl/hvac_tick_timer.sv
// Tick prescaler plus a loadable down-counter timing each FSM state.
// expired_o rises on the cycle the state should be left, so a load of N lasts N ticks (0 -> one cycle).
module hvac_tick_timer
  import hvac_pkg::*;
#(
  parameter int unsigned TickDiv = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [TimerW-1:0] load_val_i,
  output logic              tick_o,
  output logic              expired_o
);

  localparam int unsigned PreW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TickDiv - 1);

  logic [PreW-1:0]   pre_q, pre_d;
  logic [TimerW-1:0] cnt_q, cnt_d;

  assign tick_o    = (pre_q == PreMax);
  assign expired_o = (cnt_q == '0) || ((cnt_q == TimerW'(1)) && tick_o);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_i) begin
      // Restart the prescaler so every state gets whole ticks.
      pre_d = '0;
      cnt_d = load_val_i;
    end else begin
      pre_d = tick_o ? '0 : pre_q + 1'b1;
      if (tick_o && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hvac_seq_ctrl.sv
// HVAC sequencer: registered samples, hysteresis, fan lead/lag, compressor min-run and min-off.
// Drive outputs decode straight from the state register; speed is registered alongside it.
module hvac_seq_ctrl
  import hvac_pkg::*;
#(
  parameter int unsigned TW       = 8,
  parameter int unsigned HYST     = 1,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned FAN_LEAD = 4,
  parameter int unsigned MIN_RUN  = 16,
  parameter int unsigned FAN_LAG  = 8,
  parameter int unsigned MIN_OFF  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [TW-1:0] dtemp,
  input  logic [TW-1:0] atemp,
  output logic          heat,
  output logic          cool,
  output logic          idle,
  output logic          fan_on,
  output logic [1:0]    speed,
  output logic [2:0]    state_o
);

  localparam logic [TW-1:0] HystC = TW'(HYST);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [TW-1:0]     d_q, a_q;
  logic [1:0]        speed_q, speed_d;
  logic [TimerW-1:0] off_q, off_d;
  logic [TimerW-1:0] load_val;
  logic [TW-1:0]     mag;
  logic              need_heat, need_cool, done, tick, expired, off_ok;

  assign mag       = (d_q >= a_q) ? (d_q - a_q) : (a_q - d_q);
  assign need_heat = (d_q > a_q) && (mag > HystC);
  assign need_cool = (a_q > d_q) && (mag > HystC);
  assign done      = (dir_q == DirHeat) ? (a_q >= d_q) : (a_q <= d_q);
  assign off_ok    = (off_q == '0) || ((off_q == TimerW'(1)) && tick);

  hvac_tick_timer #(
    .TickDiv (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_d != state_q),
    .load_val_i (load_val),
    .tick_o     (tick),
    .expired_o  (expired)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      StIdle: begin
        if (enable && off_ok && need_heat) begin
          state_d = StPre;
          dir_d   = DirHeat;
        end else if (enable && off_ok && need_cool) begin
          state_d = StPre;
          dir_d   = DirCool;
        end
      end
      StPre: begin
        if (!enable) state_d = StIdle;
        else if (expired) state_d = StRun;
      end
      StRun: begin
        // Opposite demand is ignored here; only satisfaction or shutdown ends the run.
        if (!enable || (done && expired)) state_d = StPost;
      end
      default: begin
        if (expired) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    load_val = '0;
    case (state_d)
      StPre:   load_val = TimerW'(FAN_LEAD);
      StRun:   load_val = TimerW'(MIN_RUN);
      StPost:  load_val = TimerW'(FAN_LAG);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    off_d = off_q;
    if ((state_q == StPost) && (state_d == StIdle)) off_d = TimerW'(MIN_OFF);
    else if ((state_q == StIdle) && tick && (off_q != '0)) off_d = off_q - 1'b1;
  end

  always_comb begin
    speed_d = SpdLow;
    case (state_d)
      StIdle:  speed_d = SpdOff;
      StRun:   speed_d = run_speed(32'(mag));
      default: speed_d = SpdLow;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= DirHeat;
      d_q     <= '0;
      a_q     <= '0;
      speed_q <= SpdOff;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      off_q   <= off_d;
      if (sample_valid) begin
        d_q <= dtemp;
        a_q <= atemp;
      end
    end
  end

  assign heat    = (state_q == StRun) && (dir_q == DirHeat);
  assign cool    = (state_q == StRun) && (dir_q == DirCool);
  assign idle    = (state_q == StIdle);
  assign fan_on  = (state_q != StIdle);
  assign speed   = speed_q;
  assign state_o = {1'b0, state_q};

endmodule

// File: tb/tb_hvac_seq_ctrl.sv
// Self-checking bench for hvac_seq_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a state-age reference model of the sequencing rules.
module tb_hvac_seq_ctrl;

  localparam int HYST = 1;
  localparam int FAN_LEAD = 2;
  localparam int MIN_RUN = 4;
  localparam int FAN_LAG = 3;
  localparam int MIN_OFF = 5;

  localparam int M_IDLE = 0;
  localparam int M_PRE = 1;
  localparam int M_RUN = 2;
  localparam int M_POST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] dtemp = 8'd0;
  logic [7:0] atemp = 8'd0;
  logic       heat, cool, idle, fan_on;
  logic [1:0] speed;
  logic [2:0] state_o;
  logic [5:0] dut_v;

  int checks = 0;
  int failures = 0;

  int m_state, m_age, m_d, m_a, m_speed;
  bit m_dir_cool, m_lock;

  hvac_seq_ctrl #(
    .TW       (8),
    .HYST     (HYST),
    .TICK_DIV (1),
    .FAN_LEAD (FAN_LEAD),
    .MIN_RUN  (MIN_RUN),
    .FAN_LAG  (FAN_LAG),
    .MIN_OFF  (MIN_OFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .dtemp        (dtemp),
    .atemp        (atemp),
    .heat         (heat),
    .cool         (cool),
    .idle         (idle),
    .fan_on       (fan_on),
    .speed        (speed),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  assign dut_v = {heat, cool, idle, fan_on, speed};

  function automatic logic [5:0] model_vec();
    logic h, c, i, f;
    logic [1:0] s;
    h = (m_state == M_RUN) && !m_dir_cool;
    c = (m_state == M_RUN) && m_dir_cool;
    i = (m_state == M_IDLE);
    f = (m_state != M_IDLE);
    s = m_speed[1:0];
    return {h, c, i, f, s};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_age = 1;
    m_d = 0;
    m_a = 0;
    m_speed = 0;
    m_dir_cool = 1'b0;
    m_lock = 1'b0;
  endtask

  // Age counts cycles spent in the current state, starting at 1 on entry.
  task automatic model_update(input bit en, input bit sv, input int d, input int a);
    int diff, mag, ns;
    bit done, ok, nd;
    diff = m_d - m_a;
    mag = (diff < 0) ? -diff : diff;
    done = m_dir_cool ? (m_a <= m_d) : (m_a >= m_d);
    ns = m_state;
    nd = m_dir_cool;
    case (m_state)
      M_IDLE: begin
        ok = !m_lock || (m_age >= MIN_OFF);
        if (en && ok && diff > HYST) begin
          ns = M_PRE;
          nd = 1'b0;
        end else if (en && ok && -diff > HYST) begin
          ns = M_PRE;
          nd = 1'b1;
        end
      end
      M_PRE: begin
        if (!en) ns = M_IDLE;
        else if (m_age >= FAN_LEAD) ns = M_RUN;
      end
      M_RUN: begin
        if (!en || (done && m_age >= MIN_RUN)) ns = M_POST;
      end
      default: begin
        if (m_age >= FAN_LAG) ns = M_IDLE;
      end
    endcase
    if (ns != m_state) begin
      m_lock = (m_state == M_POST);
      m_age = 1;
    end else begin
      m_age++;
    end
    m_state = ns;
    m_dir_cool = nd;
    if (ns == M_IDLE) m_speed = 0;
    else if (ns == M_RUN) m_speed = (mag >= 6) ? 3 : (mag >= 3) ? 2 : 1;
    else m_speed = 1;
    if (sv) begin
      m_d = d;
      m_a = a;
    end
  endtask

  task automatic step(input bit en, input bit sv, input int d, input int a);
    enable = en;
    sample_valid = sv;
    dtemp = d[7:0];
    atemp = a[7:0];
    @(posedge clk);
    model_update(en, sv, d, a);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    sample_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (dut_v !== 6'b001000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", dut_v, 6'b001000);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 26, 26);
      checks++;
      if (dut_v !== model_vec() || idle !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
    end
  endtask

  task automatic test_deadband();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 26, 25);
      checks++;
      if (dut_v !== model_vec() || idle !== 1'b1) begin
        failures++;
        $display("FAIL deadband step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
    end
  endtask

  task automatic test_heat_cycle();
    int a;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a = (i < 4) ? 20 : (i == 4) ? 24 : (i < 8) ? 26 : 20;
      step(1'b1, 1'b1, 26, a);
      checks++;
      if (dut_v !== model_vec()) begin
        failures++;
        $display("FAIL heat_cycle step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
      if (i == 2) begin
        checks++;
        if ({fan_on, heat, speed} !== 4'b1001) begin
          failures++;
          $display("FAIL heat_prelead got=%b exp=%b", {fan_on, heat, speed}, 4'b1001);
        end
      end
      if (i == 3) begin
        checks++;
        if ({heat, speed} !== 3'b111) begin
          failures++;
          $display("FAIL heat_run_speed got=%b exp=%b", {heat, speed}, 3'b111);
        end
      end
      if (i == 5) begin
        checks++;
        if (speed !== 2'd1) begin
          failures++;
          $display("FAIL heat_speed_drop got=%0d exp=1", speed);
        end
      end
      if (i == 14) begin
        checks++;
        if (idle !== 1'b1) begin
          failures++;
          $display("FAIL heat_lockout got=%b exp=1", idle);
        end
      end
      if (i == 15) begin
        checks++;
        if (fan_on !== 1'b1) begin
          failures++;
          $display("FAIL heat_after_lockout got=%b exp=1", fan_on);
        end
      end
    end
  endtask

  task automatic test_cool_min_run();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 26, (i < 4) ? 32 : 26);
      checks++;
      if (dut_v !== model_vec()) begin
        failures++;
        $display("FAIL cool_min_run step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
      if (i == 3 || i == 6) begin
        checks++;
        if (cool !== 1'b1) begin
          failures++;
          $display("FAIL cool_held step=%0d got=%b exp=1", i, cool);
        end
      end
      if (i == 7) begin
        checks++;
        if ({cool, fan_on} !== 2'b01) begin
          failures++;
          $display("FAIL cool_post got=%b exp=01", {cool, fan_on});
        end
      end
    end
  endtask

  task automatic test_no_reverse();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 1'b1, 26, (i < 4) ? 20 : 32);
      checks++;
      if (dut_v !== model_vec() || (heat && cool)) begin
        failures++;
        $display("FAIL no_reverse step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
      if (i == 17) begin
        checks++;
        if ({heat, cool} !== 2'b01) begin
          failures++;
          $display("FAIL reverse_via_lockout got=%b exp=01", {heat, cool});
        end
      end
    end
  endtask

  task automatic test_enable_abort();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step((i != 4), 1'b1, 26, 20);
      checks++;
      if (dut_v !== model_vec()) begin
        failures++;
        $display("FAIL enable_abort step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
      if (i == 4) begin
        checks++;
        if ({fan_on, heat} !== 2'b10) begin
          failures++;
          $display("FAIL abort_to_post got=%b exp=10", {fan_on, heat});
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({idle, fan_on, heat, cool} !== 4'b1000) begin
      failures++;
      $display("FAIL async_reset_post got=%b exp=1000", {idle, fan_on, heat, cool});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Pulling enable during fan lead returns to IDLE without an off lockout.
    for (int i = 0; i < 6; i++) begin
      step((i != 2), (i == 0), 26, 20);
      checks++;
      if (dut_v !== model_vec()) begin
        failures++;
        $display("FAIL pre_abort step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
      if (i == 3) begin
        checks++;
        if (fan_on !== 1'b1) begin
          failures++;
          $display("FAIL pre_abort_restart got=%b exp=1", fan_on);
        end
      end
    end
  endtask

  task automatic test_random();
    bit en, sv;
    int d, a;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      sv = ($urandom_range(0, 3) == 0);
      d = $urandom_range(20, 30);
      a = $urandom_range(15, 35);
      step(en, sv, d, a);
      checks++;
      if (dut_v !== model_vec() || (heat && cool)) begin
        failures++;
        $display("FAIL random step=%0d got=%b exp=%b", i, dut_v, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_deadband();
    test_heat_cycle();
    test_cool_min_run();
    test_no_reverse();
    test_enable_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
